// File: rtl/msrv32_reg_file_sb.sv
// msrv32_reg_file_sb: parametrised integer register file with optional
// writeback-to-read bypass, a per-register busy scoreboard for stage-2 hazard
// detection, and a post-reset clear engine that zeroes one register per cycle.
module msrv32_reg_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  output logic              init_done_out,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out,
  output logic              rs_1_busy_out,
  output logic              rs_2_busy_out,
  input  logic              issue_en_in,
  input  logic [ADDR_W-1:0] issue_rd_addr_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [XLEN-1:0]   rd_in
);

  // Storage index width; NUM_REGS may be smaller than 2**ADDR_W
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_ok;
  logic                iss_ok;
  logic                clr_en;
  logic                clr_last;

  // Architecturally writable address: not x0 and inside the populated range
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  // Read port: x0/out-of-range and INIT return zero; bypass beats storage
  function automatic logic [XLEN:0] read_port(input logic [ADDR_W-1:0] a);
    if (state != READY || !addr_ok(a))
      return '0;
    if (BYPASS && wr_en_in && (rd_addr_in == a))
      return {1'b0, rd_in};
    return {busy[a[IDX_W-1:0]], regs[a[IDX_W-1:0]]};
  endfunction

  // Qualified write/issue/clear strobes
  always_comb begin
    clr_en   = !reset_in && (state == INIT);
    clr_last = (cnt == ADDR_W'(NUM_REGS - 1));
    wr_ok    = !reset_in && (state == READY) && wr_en_in && addr_ok(rd_addr_in);
    iss_ok   = !reset_in && (state == READY) && issue_en_in && addr_ok(issue_rd_addr_in);
  end

  // Clear-sequence FSM with registered ready flag
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= INIT;
      cnt           <= '0;
      init_done_out <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (clr_last) begin
        state         <= READY;
        init_done_out <= 1'b1;
      end
    end
  end

  // Register storage: cleared one entry per INIT cycle, written in READY
  always_ff @(posedge clk_in) begin
    if (clr_en)
      regs[cnt[IDX_W-1:0]] <= '0;
    else if (wr_ok)
      regs[rd_addr_in[IDX_W-1:0]] <= rd_in;
  end

  // Scoreboard: writeback clears, issue sets; issue is applied last so it wins
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      busy <= '0;
    end else if (clr_en) begin
      busy[cnt[IDX_W-1:0]] <= 1'b0;
    end else begin
      if (wr_ok)
        busy[rd_addr_in[IDX_W-1:0]] <= 1'b0;
      if (iss_ok)
        busy[issue_rd_addr_in[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Combinational read ports
  always_comb begin
    {rs_1_busy_out, rs_1_out} = read_port(rs_1_addr_in);
    {rs_2_busy_out, rs_2_out} = read_port(rs_2_addr_in);
  end

endmodule
